cpu_vram_wr_buffer: RTL and testbench

- Sits directly downstream of the HPS-to-FPGA VRAM write interface in the SoC and upstream of the VRAM write port.
- Captures CPU VRAM writes (addr/data/byte-enable) into a FIFO while the PPU is rendering.
- On the CPU's commit pulse, drains the buffered writes into VRAM only during vblank, preventing mid-frame tearing.
- Holds cpu_wr_busy high from commit acceptance until the last buffered write has landed.

---
 rtl/cpu_vram_wr_buffer.sv | 105 ++++++++++
 tb/tb_cpu_vram_wr_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_vram_wr_buffer.sv
// Buffers CPU VRAM writes in a FIFO and replays them into VRAM only during vblank
// after the CPU commits, so a frame is never torn mid-render.
module cpu_vram_wr_buffer #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64,
  parameter int BE_W   = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        h2f_wraddr,
  input  logic                     h2f_wren,
  input  logic [DATA_W-1:0]        h2f_wrdata,
  input  logic [BE_W-1:0]          h2f_byteena,
  input  logic                     h2f_commit,
  input  logic                     vblank,
  output logic [ADDR_W-1:0]        vram_wraddr,
  output logic                     vram_wren,
  output logic [DATA_W-1:0]        vram_wrdata,
  output logic [BE_W-1:0]          vram_byteena,
  output logic                     cpu_wr_busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W + BE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [ENTRY_W-1:0]   rd_entry;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full, empty, push, pop, last_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = h2f_wren && (state == IDLE) && !full;
  assign pop      = (state == DRAIN) && vblank && !empty;
  assign last_pop = pop && (count == CNT_W'(1));
  assign rd_entry = mem[rd_ptr];

  assign cpu_wr_busy = (state != IDLE);
  assign fifo_count  = count;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A write accepted in the same cycle as the commit is part of that commit.
        if (h2f_commit && (!empty || push)) state_nxt = WAIT_VB;
      end
      WAIT_VB: begin
        if (vblank) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!vblank)       state_nxt = WAIT_VB;
        else if (last_pop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {h2f_wraddr, h2f_wrdata, h2f_byteena};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push)     count <= count + CNT_W'(1);
      else if (pop) count <= count - CNT_W'(1);
      if (h2f_wren && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vram_wren    <= 1'b0;
      vram_wraddr  <= '0;
      vram_wrdata  <= '0;
      vram_byteena <= '0;
    end else begin
      vram_wren <= pop;
      if (pop) {vram_wraddr, vram_wrdata, vram_byteena} <= rd_entry;
    end
  end

endmodule

// File: tb/tb_cpu_vram_wr_buffer.sv
// Directed and randomized checks of cpu_vram_wr_buffer against a queue-based
// model of the commit/vblank write-replay rules.
module tb_cpu_vram_wr_buffer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [ADDR_W-1:0]      h2f_wraddr;
  logic                   h2f_wren;
  logic [DATA_W-1:0]      h2f_wrdata;
  logic [BE_W-1:0]        h2f_byteena;
  logic                   h2f_commit;
  logic                   vblank;
  logic [ADDR_W-1:0]      vram_wraddr;
  logic                   vram_wren;
  logic [DATA_W-1:0]      vram_wrdata;
  logic [BE_W-1:0]        vram_byteena;
  logic                   cpu_wr_busy;
  logic                   overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  cpu_vram_wr_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .h2f_wraddr   (h2f_wraddr),
    .h2f_wren     (h2f_wren),
    .h2f_wrdata   (h2f_wrdata),
    .h2f_byteena  (h2f_byteena),
    .h2f_commit   (h2f_commit),
    .vblank       (vblank),
    .vram_wraddr  (vram_wraddr),
    .vram_wren    (vram_wren),
    .vram_wrdata  (vram_wrdata),
    .vram_byteena (vram_byteena),
    .cpu_wr_busy  (cpu_wr_busy),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [BE_W-1:0]   b;
  } entry_t;

  // Model: pending writes, whether a commit is outstanding, and whether vblank
  // has already been seen on an earlier edge of this commit (a pop needs both).
  entry_t q[$];
  bit     m_busy, m_armed, m_ovf, m_wren;
  entry_t m_out;

  int checks = 0;
  int fails  = 0;
  int n_wr   = 0;
  int base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit     rst, wr, vb, acc, pop, go;
    entry_t e;
    rst = reset;
    wr  = h2f_wren;
    vb  = vblank;
    e.a = h2f_wraddr;
    e.d = h2f_wrdata;
    e.b = h2f_byteena;
    acc = wr && !m_busy && (q.size() < DEPTH);
    pop = m_busy && m_armed && vb && (q.size() > 0);
    go  = !m_busy && h2f_commit && (q.size() > 0 || acc);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_busy = 0; m_armed = 0; m_ovf = 0; m_wren = 0; m_out = '0;
    end else begin
      if (wr && !acc) m_ovf = 1;
      m_armed = m_busy && vb;
      m_wren  = pop;
      if (pop) m_out = q.pop_front();
      if (acc) q.push_back(e);
      if (go) m_busy = 1;
      if (pop && q.size() == 0) begin
        m_busy  = 0;
        m_armed = 0;
      end
    end
    if (vram_wren === 1'b1) n_wr++;
    chk("vram_wren",    64'(vram_wren),    64'(m_wren));
    chk("vram_wraddr",  64'(vram_wraddr),  64'(m_out.a));
    chk("vram_wrdata",  64'(vram_wrdata),  64'(m_out.d));
    chk("vram_byteena", 64'(vram_byteena), 64'(m_out.b));
    chk("cpu_wr_busy",  64'(cpu_wr_busy),  64'(m_busy));
    chk("overflow",     64'(overflow),     64'(m_ovf));
    chk("fifo_count",   64'(fifo_count),   64'(q.size()));
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [BE_W-1:0] b);
    h2f_wren    = 1'b1;
    h2f_wraddr  = a;
    h2f_wrdata  = d;
    h2f_byteena = b;
    step();
    h2f_wren = 1'b0;
  endtask

  task automatic rand_writes(input int n);
    for (int i = 0; i < n; i++)
      cpu_write(ADDR_W'($urandom), {$urandom, $urandom}, BE_W'($urandom));
  endtask

  task automatic commit();
    h2f_commit = 1'b1;
    step();
    h2f_commit = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; h2f_wren = 1'b0; h2f_commit = 1'b0; vblank = 1'b0;
    h2f_wraddr = '0; h2f_wrdata = '0; h2f_byteena = '0;
    step();
    step();
    reset = 1'b0;
    step();

    // Basic commit with vblank held high
    vblank = 1'b1;
    base = n_wr;
    cpu_write(13'h0010, {8'hA5, 56'($urandom)}, 8'hFF);
    cpu_write(13'h0011, {8'hA5, 56'($urandom)}, 8'h0F);
    cpu_write(13'h1FFF, {8'hA5, 56'($urandom)}, 8'h80);
    commit();
    repeat (8) step();
    chk("basic_count", 64'(n_wr - base), 64'd3);

    // Vblank gating
    vblank = 1'b0;
    base = n_wr;
    rand_writes(4);
    commit();
    repeat (20) step();
    chk("gated_no_wr", 64'(n_wr - base), 64'd0);
    chk("gated_busy", 64'(cpu_wr_busy), 64'd1);
    vblank = 1'b1;
    step();
    chk("gated_lat1", 64'(vram_wren), 64'd0);
    step();
    chk("gated_lat2", 64'(vram_wren), 64'd1);
    repeat (6) step();
    chk("gated_count", 64'(n_wr - base), 64'd4);

    // Vblank drop mid-drain
    vblank = 1'b1;
    base = n_wr;
    rand_writes(8);
    commit();
    repeat (4) step();
    chk("drop_first", 64'(n_wr - base), 64'd3);
    vblank = 1'b0;
    repeat (10) step();
    chk("drop_gap", 64'(n_wr - base), 64'd3);
    vblank = 1'b1;
    repeat (12) step();
    chk("drop_total", 64'(n_wr - base), 64'd8);

    // Full FIFO and overflow
    vblank = 1'b0;
    base = n_wr;
    rand_writes(DEPTH + 2);
    chk("full_count", 64'(fifo_count), 64'(DEPTH));
    chk("full_ovf", 64'(overflow), 64'd1);
    vblank = 1'b1;
    commit();
    repeat (DEPTH + 6) step();
    chk("full_drained", 64'(n_wr - base), 64'(DEPTH));
    chk("full_ovf_kept", 64'(overflow), 64'd1);

    // Spurious commits and writes while busy
    do_reset();
    vblank = 1'b0;
    commit();
    chk("empty_commit", 64'(cpu_wr_busy), 64'd0);
    rand_writes(2);
    commit();
    commit();
    rand_writes(1);
    chk("wait_wr_ovf", 64'(overflow), 64'd1);
    vblank = 1'b1;
    step();
    rand_writes(1);
    repeat (5) step();
    chk("busy_wr_idle", 64'(cpu_wr_busy), 64'd0);
    base = n_wr;
    h2f_wren = 1'b1; h2f_commit = 1'b1;
    h2f_wraddr = 13'h0ABC; h2f_wrdata = {$urandom, $urandom}; h2f_byteena = 8'h3C;
    step();
    h2f_wren = 1'b0; h2f_commit = 1'b0;
    repeat (6) step();
    chk("same_cycle", 64'(n_wr - base), 64'd1);

    // Reset mid-drain
    do_reset();
    vblank = 1'b1;
    rand_writes(10);
    commit();
    base = n_wr;
    for (int i = 0; i < 40 && (n_wr - base) < 4; i++) step();
    chk("mid_pulses", 64'(n_wr - base), 64'd4);
    do_reset();
    chk("mid_wren", 64'(vram_wren), 64'd0);
    chk("mid_count", 64'(fifo_count), 64'd0);
    base = n_wr;
    commit();
    repeat (5) step();
    chk("mid_after", 64'(n_wr - base), 64'd0);
    chk("mid_busy", 64'(cpu_wr_busy), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      h2f_wren    = ($urandom_range(1, 0) == 1);
      h2f_commit  = ($urandom_range(15, 0) == 0);
      h2f_wraddr  = ADDR_W'($urandom);
      h2f_wrdata  = {$urandom, $urandom};
      h2f_byteena = BE_W'($urandom);
      if ($urandom_range(7, 0) == 0) vblank = ~vblank;
      reset = ($urandom_range(199, 0) == 0);
      step();
    end
    h2f_wren = 1'b0; h2f_commit = 1'b0; reset = 1'b0; vblank = 1'b1;
    repeat (DEPTH + 4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
